// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: the mainMem read port, the branch redirect from execute and the
// valid/ready instruction handoff to decode. Fetch is the master; memory/execute/decode the slave.
interface fetch_unit_if #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int ACCESS_SIZE  = 2
);
  logic [ADDRESS_SIZE-1:0] mem_addr;
  logic [ACCESS_SIZE-1:0]  mem_acc_size;
  logic                    mem_wren;
  logic                    mem_en;
  logic [DATA_SIZE-1:0]    mem_d_out;
  logic                    mem_busy;
  logic                    branch_taken;
  logic [ADDRESS_SIZE-1:0] branch_target;
  logic                    insn_ready;
  logic                    insn_valid;
  logic [DATA_SIZE-1:0]    insn_out;
  logic [ADDRESS_SIZE-1:0] pc_out;

  modport master (
    output mem_addr, mem_acc_size, mem_wren, mem_en, insn_valid, insn_out, pc_out,
    input  mem_d_out, mem_busy, branch_taken, branch_target, insn_ready
  );

  modport slave (
    input  mem_addr, mem_acc_size, mem_wren, mem_en, insn_valid, insn_out, pc_out,
    output mem_d_out, mem_busy, branch_taken, branch_target, insn_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, read-only mainMem requests, valid/ready handoff to decode.
// Define FETCH_BURST_EN for 4-word burst fills into a line buffer served at 1 insn/cycle.
module fetch_unit #(
  parameter int                     ADDRESS_SIZE  = 32,
  parameter int                     DATA_SIZE     = 32,
  parameter int                     ACCESS_SIZE   = 2,
  parameter logic [ADDRESS_SIZE-1:0] START_ADDRESS = 32'h80020000
) (
  input logic           clk,
  input logic           rst_n,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {IDLE, REQ, GAP, HOLD} state_t;

  state_t                  state;
  logic [ADDRESS_SIZE-1:0] pc;
  logic                    handshake;
  logic [ADDRESS_SIZE-1:0] pc_seq;
  logic [ADDRESS_SIZE-1:0] target;

  // pc always names the instruction on insn_out (or the one being fetched);
  // pc_seq is where the stream stands once this edge's transfer is accounted for.
  assign handshake = bus.insn_valid && bus.insn_ready;
  assign pc_seq    = handshake ? pc + ADDRESS_SIZE'(4) : pc;
  assign target    = {bus.branch_target[ADDRESS_SIZE-1:2], 2'b00};

  assign bus.mem_wren = 1'b0;

`ifdef FETCH_BURST_EN
  logic [DATA_SIZE-1:0]    line_buf [4];
  logic [ADDRESS_SIZE-5:0] line_tag;
  logic                    line_valid;
  logic [1:0]              beat;
  logic                    line_hit;
  logic                    target_hit;

  assign line_hit   = line_valid && (line_tag == pc_seq[ADDRESS_SIZE-1:4]);
  assign target_hit = line_valid && (line_tag == target[ADDRESS_SIZE-1:4]);
`endif

  // NOTE: sequential state uses non-blocking assignments only; where two NBAs hit the
  // same register in one block the later one wins, so a capture overrides the
  // handshake's clear of insn_valid on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      pc               <= START_ADDRESS;
      bus.mem_en       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_acc_size <= '0;
      bus.insn_valid   <= 1'b0;
      bus.insn_out     <= '0;
      bus.pc_out       <= START_ADDRESS;
`ifdef FETCH_BURST_EN
      // NOTE: line_buf is deliberately not reset; line_valid alone qualifies its contents.
      line_valid       <= 1'b0;
      line_tag         <= '0;
      beat             <= '0;
`endif
    end else if (bus.branch_taken) begin
      // Redirect beats any capture or transfer on this edge.
      pc             <= target;
      bus.insn_valid <= 1'b0;
      bus.mem_en     <= 1'b0;
      state          <= GAP;
`ifdef FETCH_BURST_EN
      beat           <= '0;
      if (!target_hit) line_valid <= 1'b0;
`endif
    end else begin
      pc <= pc_seq;
      if (handshake) bus.insn_valid <= 1'b0;

`ifdef FETCH_BURST_EN
      case (state)
        REQ: begin
          if (!bus.mem_busy) begin
            line_buf[beat] <= bus.mem_d_out;
            beat           <= beat + 2'd1;
            if (beat == 2'd3) begin
              bus.mem_en <= 1'b0;
              line_valid <= 1'b1;
              state      <= GAP;
            end
          end
        end
        default: begin
          if (!bus.insn_valid || handshake) begin
            if (line_hit) begin
              bus.insn_valid <= 1'b1;
              bus.insn_out   <= line_buf[pc_seq[3:2]];
              bus.pc_out     <= pc_seq;
              state          <= GAP;
            end else begin
              // pc has left the buffered line: refill the whole aligned line.
              bus.mem_en       <= 1'b1;
              bus.mem_addr     <= {pc_seq[ADDRESS_SIZE-1:4], 4'b0000};
              bus.mem_acc_size <= ACCESS_SIZE'(1);
              line_tag         <= pc_seq[ADDRESS_SIZE-1:4];
              line_valid       <= 1'b0;
              beat             <= '0;
              state            <= REQ;
            end
          end else begin
            state <= HOLD;
          end
        end
      endcase
`else
      case (state)
        IDLE: begin
          bus.mem_en       <= 1'b1;
          bus.mem_addr     <= pc_seq;
          bus.mem_acc_size <= '0;
          state            <= REQ;
        end
        REQ: begin
          bus.insn_out   <= bus.mem_d_out;
          bus.pc_out     <= bus.mem_addr;
          bus.insn_valid <= 1'b1;
          bus.mem_en     <= 1'b0;
          state          <= GAP;
        end
        GAP: begin
          // mem_en must spend a cycle low so mainMem's burst counter clears.
          if (bus.insn_valid && !bus.insn_ready) begin
            state <= HOLD;
          end else begin
            bus.mem_en       <= 1'b1;
            bus.mem_addr     <= pc_seq;
            bus.mem_acc_size <= '0;
            state            <= REQ;
          end
        end
        HOLD: begin
          if (bus.insn_ready) begin
            bus.mem_en       <= 1'b1;
            bus.mem_addr     <= pc_seq;
            bus.mem_acc_size <= '0;
            state            <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
`endif
    end
  end

endmodule
